m_unit: RTL and testbench
=========================

Name: m_unit

Overview:
- Iterative RV32M multiply/divide execution unit, placed beside the execute stage of the rv32i pipeline.
- The pipeline issues an M-type operation to this unit. The unit computes the result over multiple cycles, signals busy so the hazard unit stalls, then returns the result, destination register and write-enable for the EX/MEM path.
- This block is the responder side of the core's m_unit_busy / m_unit_ready / m_unit_result / m_unit_dest / m_unit_wr interface.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe for an M-type instruction in EX; sampled only in IDLE.
- flush  in  1  pipeline flush (ex_forward_pipeline_flush or jump_en); aborts an in-flight operation.
- func3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  in  32  rs1 value, already forwarded.
- op2  in  32  rs2 value, already forwarded.
- rd  in  5  destination register.
- m_unit_busy  out  1  operation in progress; core must stall.
- m_unit_ready  out  1  one-cycle result-valid pulse.
- m_unit_result  out  32  result.
- m_unit_dest  out  5  destination register of the result.
- m_unit_wr  out  1  register-file write enable, equal to m_unit_ready && (m_unit_dest != 0).

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE; busy, ready, wr, result, dest and all internal registers are 0. A reset during CALC or DONE drops everything immediately with no ready pulse.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - Latch func3 and rd.
  - Latch |op1| and |op2|, using signed interpretation per op; MULHSU treats only op1 as signed.
  - Latch the result sign.
  - Clear the 5-bit counter.
  - Go to CALC, or go directly to DONE for the special cases below.
- IDLE, start=1 and flush=1: start is ignored.
- CALC, one step per cycle:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
  - When counter=31, go to DONE. CALC always lasts exactly 32 cycles.
- DONE, for exactly one cycle:
  - ready=1.
  - result = sign-corrected value: MUL gives low 32 bits; MULH/MULHSU/MULHU give high 32 bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Quotient is negated when operand signs differ. Remainder takes the sign of the dividend.
  - Then go to IDLE.
- Latency: start sampled at edge N. Normal ops show ready during the cycle after edge N+32 (33 cycles). Special cases show ready during the cycle after edge N (1 cycle).
- busy=1 exactly while state is CALC; busy=0 in DONE and IDLE. Hazard stall is busy || ready.
- Special cases resolved at start, skipping CALC:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM with the same operands gives 0.
- result and dest are registered, valid during the ready cycle, and held until the next accepted start.
- start while busy or in DONE: ignored; no queuing.
- flush in CALC: next edge goes to IDLE, busy drops, no ready pulse, result is not updated.
- flush in DONE: ignored; the result is committed.
- Arithmetic: all intermediate values are unsigned magnitudes. Negation is two's complement at XLEN (or 2*XLEN for products) bits; wrap-around is discarded.

Decomposition:
- Shared package m_unit_pkg holds:
  - the func3 encoding localparams (M_MUL..M_REMU);
  - the state encoding (S_IDLE, S_CALC, S_DONE);
  - the RV32M opcode/funct7 constants (0110011 / 0000001) used by the decoder.
- One sub-module is natural: m_unit_divider, a single-step restoring divide iteration (remainder/quotient in, remainder/quotient out). It is instantiated once; the multiply step stays inline.

Test Plan:
- MUL 7×6, rd=5, start at edge N → busy for 32 cycles; in the cycle after edge N+32: ready=1, result=0x0000002A, dest=5, wr=1; ready low the next cycle.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF; MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; REM 7/-2 → 1.
- DIV 5/0 → 0xFFFFFFFF with ready one cycle after start and busy never high; REMU 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM same operands → 0.
- Start MUL, assert flush on the 10th CALC cycle → busy=0 next cycle, no ready pulse; a new start next cycle is accepted with normal 33-cycle latency.
- rd=0 → ready=1, wr=0. start pulsed during CALC → ignored, result unchanged. rst low mid-CALC → all outputs 0 immediately; after reset, a new op completes correctly.

Source files
------------

// File: rtl/m_unit_pkg.sv
// m_unit_pkg: shared definitions for the RV32M multiply/divide unit.
//   - func3 encodings of the eight RV32M operations
//   - FSM state encoding (IDLE -> CALC -> DONE)
//   - opcode/funct7 pair that identifies an M-type instruction in the decoder
package m_unit_pkg;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/m_unit_if.sv
// m_unit_if: issue/response bundle between the execute stage and the M unit.
//   master (core side): drives start, flush, func3, op1, op2, rd;
//                       receives busy, ready, result, dest, wr.
//   slave  (m_unit)   : the mirror image.
interface m_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd;

  logic            m_unit_busy;
  logic            m_unit_ready;
  logic [XLEN-1:0] m_unit_result;
  logic [4:0]      m_unit_dest;
  logic            m_unit_wr;

  modport master (
    output start, flush, func3, op1, op2, rd,
    input  m_unit_busy, m_unit_ready, m_unit_result, m_unit_dest, m_unit_wr
  );

  modport slave (
    input  start, flush, func3, op1, op2, rd,
    output m_unit_busy, m_unit_ready, m_unit_result, m_unit_dest, m_unit_wr
  );
endinterface

// File: rtl/m_unit_divider.sv
// m_unit_divider: one iteration of an unsigned restoring divider.
//   rem_i/quot_i : partial remainder and the quotient register, which still
//                  holds the not-yet-consumed dividend bits in its upper end
//   divisor_i    : divisor magnitude
//   rem_o/quot_o : state after shifting in one dividend bit and trying a
//                  subtraction
// After XLEN iterations starting from rem=0, quot=dividend, quot_o holds the
// quotient and rem_o the remainder.
module m_unit_divider #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // One extra bit: the shifted remainder can reach 2*divisor-1, and a set
  // MSB of the difference means the trial subtraction went negative.
  assign shifted = {rem_i, quot_i[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  always_comb begin
    if (!diff[XLEN]) begin
      rem_o  = diff[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o  = shifted[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/m_unit.sv
// m_unit: iterative RV32M multiply/divide unit beside the EX stage.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : m_unit_if.slave -- start/flush/func3/op1/op2/rd in;
//          m_unit_busy (stall), m_unit_ready (1-cycle result pulse),
//          m_unit_result, m_unit_dest, m_unit_wr out.
// Operands are converted to unsigned magnitudes at issue, the unit runs 32
// shift-add or shift-subtract steps, and the sign is restored at the end.
// Divide-by-zero and signed overflow are answered at issue without CALC.
module m_unit
  import m_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  m_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                          input logic is_signed);
    return (is_signed && v[XLEN-1]) ? neg_x(v) : v;
  endfunction

  // Apply the latched result sign and select the field the op returns.
  // Divide keeps {remainder, quotient} in the accumulator halves.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0]    f,
                                               input logic          neg,
                                               input logic [W2-1:0] acc);
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    prod = neg ? neg_w2(acc) : acc;
    quot = neg ? neg_x(acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg ? neg_x(acc[W2-1:XLEN]) : acc[W2-1:XLEN];
    case (f)
      M_MUL:                    return prod[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: return prod[W2-1:XLEN];
      M_DIV, M_DIVU:            return quot;
      default:                  return rem;
    endcase
  endfunction

  state_t          state_q,  state_d;
  logic [2:0]      func3_q,  func3_d;
  logic [XLEN-1:0] a_mag_q,  a_mag_d;
  logic [XLEN-1:0] b_mag_q,  b_mag_d;
  logic            neg_q,    neg_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [W2-1:0]   acc_q,    acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      dest_q,   dest_d;

  logic            op1_signed;
  logic            op2_signed;
  logic [XLEN-1:0] op1_mag;
  logic [XLEN-1:0] op2_mag;
  logic            res_neg;
  logic            div_by_zero;
  logic            div_ovf;

  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_quot;
  logic [W2-1:0]   mul_addend;

  // Issue-time decode of the incoming operation.
  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (bus.func3)
      M_MULH, M_DIV, M_REM: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      M_MULHSU: op1_signed = 1'b1;
      default: ;
    endcase
    op1_mag = mag(bus.op1, op1_signed);
    op2_mag = mag(bus.op2, op2_signed);
    // Remainder follows the dividend; everything else is the XOR of signs.
    if (bus.func3 == M_REM)
      res_neg = op1_signed & bus.op1[XLEN-1];
    else
      res_neg = (op1_signed & bus.op1[XLEN-1]) ^ (op2_signed & bus.op2[XLEN-1]);
    div_by_zero = bus.func3[2] && (bus.op2 == '0);
    div_ovf     = ((bus.func3 == M_DIV) || (bus.func3 == M_REM)) &&
                  (bus.op1 == XMIN) && (bus.op2 == '1);
  end

  m_unit_divider #(.XLEN(XLEN)) u_divider (
    .rem_i     (acc_q[W2-1:XLEN]),
    .quot_i    (acc_q[XLEN-1:0]),
    .divisor_i (b_mag_q),
    .rem_o     (div_rem),
    .quot_o    (div_quot)
  );

  // Radix-2 multiply: multiplier bit cnt selects multiplicand << cnt.
  assign mul_addend = b_mag_q[cnt_q] ? ({{XLEN{1'b0}}, a_mag_q} << cnt_q) : '0;

  always_comb begin
    state_d  = state_q;
    func3_d  = func3_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    dest_d   = dest_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          func3_d = bus.func3;
          dest_d  = bus.rd;
          a_mag_d = op1_mag;
          b_mag_d = op2_mag;
          neg_d   = res_neg;
          cnt_d   = '0;
          acc_d   = bus.func3[2] ? {{XLEN{1'b0}}, op1_mag} : '0;
          if (div_by_zero) begin
            result_d = bus.func3[1] ? bus.op1 : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = bus.func3[1] ? '0 : XMIN;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          acc_d = func3_q[2] ? {div_rem, div_quot} : (acc_q + mul_addend);
          if (cnt_q == CW'(XLEN - 1)) begin
            result_d = finalize(func3_q, neg_q, acc_d);
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      func3_q  <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      func3_q  <= func3_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      dest_q   <= dest_d;
    end
  end

  assign bus.m_unit_busy   = (state_q == S_CALC);
  assign bus.m_unit_ready  = (state_q == S_DONE);
  assign bus.m_unit_result = result_q;
  assign bus.m_unit_dest   = dest_q;
  assign bus.m_unit_wr     = (state_q == S_DONE) && (dest_q != 5'd0);

endmodule

// File: tb/tb_m_unit.sv
// tb_m_unit: self-checking bench for m_unit (directed cases, special cases,
// flush, reset, and randomized operations against an arithmetic model).
module tb_m_unit;
  import m_unit_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  m_unit_if #(.XLEN(32)) bus();

  m_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      M_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      M_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      M_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      M_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      M_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return 32'(sa / sb);
      end
      M_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      M_REM: begin
        if (b == 32'd0) return a;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 32'd0) ||
           (((f == M_DIV) || (f == M_REM)) && (a == 32'h8000_0000) &&
            (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Drive one start pulse; returns at the negedge right after the sampling edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = f;
    bus.op1   = a;
    bus.op2   = b;
    bus.rd    = r;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges until ready (bounded), and how many of them showed busy.
  task automatic wait_ready(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!bus.m_unit_ready && lat < 100) begin
      if (bus.m_unit_busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func3 = 3'd0;
    bus.op1   = 32'd0;
    bus.op2   = 32'd0;
    bus.rd    = 5'd0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.m_unit_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.m_unit_busy); end
    total++; if (bus.m_unit_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.m_unit_ready); end
    total++; if (bus.m_unit_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b want=0", bus.m_unit_wr); end
    total++; if (bus.m_unit_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.m_unit_result); end
    total++; if (bus.m_unit_dest !== 5'd0) begin bad++; $display("FAIL reset_dest got=%0d want=0", bus.m_unit_dest); end
    rst = 1'b1;
  endtask

  task automatic test_mul_basic();
    int lat, bcnt;
    issue(M_MUL, 32'd7, 32'd6, 5'd5);
    wait_ready(lat, bcnt);
    total++; if (lat !== 32) begin bad++; $display("FAIL mul_latency got=%0d want=32", lat); end
    total++; if (bcnt !== 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=32", bcnt); end
    total++; if (bus.m_unit_result !== 32'h2A) begin bad++; $display("FAIL mul_result got=%h want=0000002a", bus.m_unit_result); end
    total++; if (bus.m_unit_dest !== 5'd5) begin bad++; $display("FAIL mul_dest got=%0d want=5", bus.m_unit_dest); end
    total++; if (bus.m_unit_wr !== 1'b1) begin bad++; $display("FAIL mul_wr got=%b want=1", bus.m_unit_wr); end
    @(negedge clk);
    total++; if (bus.m_unit_ready !== 1'b0) begin bad++; $display("FAIL mul_ready_drop got=%b want=0", bus.m_unit_ready); end
    total++; if (bus.m_unit_result !== 32'h2A) begin bad++; $display("FAIL mul_result_hold got=%h want=0000002a", bus.m_unit_result); end
  endtask

  task automatic test_directed();
    logic [2:0]  fv [9];
    logic [31:0] av [9];
    logic [31:0] bv [9];
    logic [31:0] ev [9];
    int lat, bcnt;
    fv = '{M_MULH, M_MULHU, M_MULHSU, M_MUL, M_DIV, M_REM, M_DIVU, M_REMU, M_REM};
    av = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7};
    bv = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
           32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE};
    ev = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd1};
    for (int i = 0; i < 9; i++) begin
      issue(fv[i], av[i], bv[i], 5'd10);
      wait_ready(lat, bcnt);
      total++; if (bus.m_unit_result !== ev[i]) begin bad++; $display("FAIL directed_%0d result got=%h want=%h", i, bus.m_unit_result, ev[i]); end
      total++; if (lat !== 32) begin bad++; $display("FAIL directed_%0d latency got=%0d want=32", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv [5];
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic [31:0] ev [5];
    int lat, bcnt;
    fv = '{M_DIV, M_REMU, M_DIV, M_REM, M_DIVU};
    av = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
    bv = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    ev = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      issue(fv[i], av[i], bv[i], 5'd7);
      wait_ready(lat, bcnt);
      total++; if (bus.m_unit_result !== ev[i]) begin bad++; $display("FAIL special_%0d result got=%h want=%h", i, bus.m_unit_result, ev[i]); end
      total++; if (lat !== 0) begin bad++; $display("FAIL special_%0d latency got=%0d want=0", i, lat); end
      total++; if (bus.m_unit_busy !== 1'b0) begin bad++; $display("FAIL special_%0d busy got=%b want=0", i, bus.m_unit_busy); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int lat, bcnt;
    prev = bus.m_unit_result;
    issue(M_MUL, 32'h1234, 32'h10, 5'd4);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    total++; if (bus.m_unit_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus.m_unit_busy); end
    total++; if (bus.m_unit_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", bus.m_unit_ready); end
    total++; if (bus.m_unit_result !== prev) begin bad++; $display("FAIL flush_result got=%h want=%h", bus.m_unit_result, prev); end
    // Restart in the very next cycle.
    bus.start = 1'b1;
    bus.func3 = M_MULHU;
    bus.op1   = 32'hDEAD_BEEF;
    bus.op2   = 32'h1234_5678;
    bus.rd    = 5'd12;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready(lat, bcnt);
    total++; if (lat !== 32) begin bad++; $display("FAIL flush_restart_latency got=%0d want=32", lat); end
    total++; if (bus.m_unit_result !== model(M_MULHU, 32'hDEAD_BEEF, 32'h1234_5678)) begin bad++; $display("FAIL flush_restart_result got=%h want=%h", bus.m_unit_result, model(M_MULHU, 32'hDEAD_BEEF, 32'h1234_5678)); end
  endtask

  task automatic test_rd_zero();
    int lat, bcnt;
    issue(M_MUL, 32'd3, 32'd3, 5'd0);
    wait_ready(lat, bcnt);
    total++; if (bus.m_unit_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%b want=1", bus.m_unit_ready); end
    total++; if (bus.m_unit_wr !== 1'b0) begin bad++; $display("FAIL rd0_wr got=%b want=0", bus.m_unit_wr); end
    total++; if (bus.m_unit_result !== 32'd9) begin bad++; $display("FAIL rd0_result got=%h want=9", bus.m_unit_result); end
  endtask

  task automatic test_start_in_calc();
    int lat, bcnt, pulses;
    issue(M_DIVU, 32'd1000, 32'd10, 5'd3);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = M_MUL;
    bus.op1   = 32'd2;
    bus.op2   = 32'd2;
    bus.rd    = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready(lat, bcnt);
    total++; if (lat + 6 !== 32) begin bad++; $display("FAIL calc_start_latency got=%0d want=32", lat + 6); end
    total++; if (bus.m_unit_result !== 32'd100) begin bad++; $display("FAIL calc_start_result got=%h want=64", bus.m_unit_result); end
    total++; if (bus.m_unit_dest !== 5'd3) begin bad++; $display("FAIL calc_start_dest got=%0d want=3", bus.m_unit_dest); end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.m_unit_ready) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL calc_start_extra_ready got=%0d want=0", pulses); end
    total++; if (bus.m_unit_result !== 32'd100) begin bad++; $display("FAIL calc_start_hold got=%h want=64", bus.m_unit_result); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bcnt;
    issue(M_MULH, 32'h7000_0000, 32'h7000_0000, 5'd21);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.m_unit_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.m_unit_busy); end
    total++; if (bus.m_unit_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", bus.m_unit_ready); end
    total++; if (bus.m_unit_result !== 32'd0) begin bad++; $display("FAIL rstmid_result got=%h want=0", bus.m_unit_result); end
    total++; if (bus.m_unit_dest !== 5'd0) begin bad++; $display("FAIL rstmid_dest got=%0d want=0", bus.m_unit_dest); end
    total++; if (bus.m_unit_wr !== 1'b0) begin bad++; $display("FAIL rstmid_wr got=%b want=0", bus.m_unit_wr); end
    @(negedge clk);
    rst = 1'b1;
    issue(M_MUL, 32'd3, 32'd5, 5'd2);
    wait_ready(lat, bcnt);
    total++; if (lat !== 32) begin bad++; $display("FAIL rstmid_after_latency got=%0d want=32", lat); end
    total++; if (bus.m_unit_result !== 32'd15) begin bad++; $display("FAIL rstmid_after_result got=%h want=f", bus.m_unit_result); end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    logic [4:0]  r;
    int lat, bcnt, exp_lat;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      r = 5'($urandom_range(0, 31));
      exp = model(f, a, b);
      exp_lat = is_special(f, a, b) ? 0 : 32;
      issue(f, a, b, r);
      wait_ready(lat, bcnt);
      total++; if (bus.m_unit_result !== exp) begin bad++; $display("FAIL rand_%0d result f=%0d a=%h b=%h got=%h want=%h", i, f, a, b, bus.m_unit_result, exp); end
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL rand_%0d latency got=%0d want=%0d", i, lat, exp_lat); end
      total++; if (bcnt !== exp_lat) begin bad++; $display("FAIL rand_%0d busy_cycles got=%0d want=%0d", i, bcnt, exp_lat); end
      total++; if (bus.m_unit_dest !== r) begin bad++; $display("FAIL rand_%0d dest got=%0d want=%0d", i, bus.m_unit_dest, r); end
      total++; if (bus.m_unit_wr !== (r != 5'd0)) begin bad++; $display("FAIL rand_%0d wr got=%b want=%b", i, bus.m_unit_wr, (r != 5'd0)); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_directed();
    test_special();
    test_flush();
    test_rd_zero();
    test_start_in_calc();
    test_reset_mid_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
